// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the binary-to-BCD converter
// Purpose: FSM state encoding, BCD digit type and the double-dabble adjust constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t ADJ_THRESH = 4'd5;
  localparam bcd_digit_t ADJ_VALUE  = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - per-digit add-3 correction for double dabble
// Purpose: a digit that is 5 or more gets +3 before the next left shift, so the
//          shift carries into the next digit exactly when the value reaches 10.
// Ports:
//   digit_i  in   4  current work digit
//   digit_o  out  4  corrected digit (digit_i >= 5 ? digit_i + 3 : digit_i)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= ADJ_THRESH) begin
      digit_o = digit_i + ADJ_VALUE;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter
// Purpose: converts bin_in to packed BCD one bit per clock with a start/busy/done
//          handshake; bcd_out/overflow update only when a conversion completes.
// Ports:
//   clk       in   1         system clock, posedge
//   reset     in   1         asynchronous active-high reset
//   start     in   1         conversion request, honoured only in IDLE
//   bin_in    in   BIN_W     binary value, captured when start is accepted
//   busy      out  1         conversion in progress (SHIFT or DONE)
//   done      out  1         one-cycle completion pulse
//   bcd_out   out  4*DIGITS  packed BCD result, units digit in [3:0]
//   overflow  out  1         last converted value was >= 10**DIGITS
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  // Wide enough for both the input and 10**DIGITS (which is below 2**W).
  localparam int CMP_W = (BIN_W + 1 > W + 1) ? BIN_W + 1 : W + 1;

  function automatic logic [CMP_W-1:0] pow10(input int n);
    logic [CMP_W-1:0] r;
    r = '0;
    r[0] = 1'b1;
    for (int i = 0; i < n; i++) begin
      r = r * CMP_W'(10);
    end
    return r;
  endfunction

  localparam logic [CMP_W-1:0] LIMIT = pow10(DIGITS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [W-1:0]       work_q, work_d;
  logic [W-1:0]       bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               ovf_cap_q, ovf_cap_d;
  logic [W-1:0]       adj_w;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (work_q[4*g +: 4]),
      .digit_o (adj_w[4*g +: 4])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      work_q    <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      ovf_cap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      work_q    <= work_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      ovf_cap_q <= ovf_cap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    work_d    = work_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    ovf_cap_d = ovf_cap_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          bin_d     = bin_in;
          work_d    = '0;
          cnt_d     = CNT_W'(BIN_W);
          ovf_cap_d = ({{(CMP_W-BIN_W){1'b0}}, bin_in} >= LIMIT);
        end
      end
      SHIFT: begin
        // {work, bin} shifts left as one register; the work MSB falls off,
        // which is what makes bcd_out equal bin_in mod 10**DIGITS.
        work_d = (adj_w << 1) | W'(bin_q[BIN_W-1]);
        bin_d  = bin_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          bcd_d   = work_d;
          ovf_d   = ovf_cap_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard testbench for bin2bcd_seq
module tb_bin2bcd_seq;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;
  localparam int LAT    = BIN_W + 1;  // negedges from start drive to done
  localparam int PERIOD = BIN_W + 2;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [BIN_W-1:0]  bin_in;
  logic              busy;
  logic              done;
  logic [15:0]       bcd_out;
  logic              overflow;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int v);
    exp_t e;
    int   r;
    r = v % 10000;
    for (int i = 0; i < 4; i++) begin
      e.bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.ovf = (v >= 10000);
    return e;
  endfunction

  // Drives one start pulse and waits (bounded) for done; records what it saw.
  task automatic run_conv(input int v, output int lat, output logic busy1,
                          output logic [15:0] bcd, output logic ovf);
    @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(v);
    sb.push_back(model(v));
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    busy1 = busy;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    bcd = bcd_out;
    ovf = overflow;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (bcd_out !== 16'h0000) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", bcd_out); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
  endtask

  task automatic test_basic();
    int lat; logic b1; logic [15:0] bcd; logic ovf; exp_t e;
    run_conv(1234, lat, b1, bcd, ovf);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%0b exp=1", b1); end
    checks++; if (lat != LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bcd !== e.bcd) begin failures++; $display("FAIL basic_bcd got=%h exp=%h", bcd, e.bcd); end
    checks++; if (ovf !== e.ovf) begin failures++; $display("FAIL basic_ovf got=%0b exp=%0b", ovf, e.ovf); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%0b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_fall got=%0b exp=0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (bcd_out !== e.bcd) begin failures++; $display("FAIL basic_hold got=%h exp=%h", bcd_out, e.bcd); end
  endtask

  task automatic test_values();
    int vals[5] = '{0, 9999, 16383, 10000, 1};
    int lat; logic b1; logic [15:0] bcd; logic ovf; exp_t e;
    foreach (vals[i]) begin
      run_conv(vals[i], lat, b1, bcd, ovf);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      checks++; if (lat != LAT) begin failures++; $display("FAIL values_latency v=%0d got=%0d exp=%0d", vals[i], lat, LAT); end
      checks++; if (bcd !== e.bcd) begin failures++; $display("FAIL values_bcd v=%0d got=%h exp=%h", vals[i], bcd, e.bcd); end
      checks++; if (ovf !== e.ovf) begin failures++; $display("FAIL values_ovf v=%0d got=%0b exp=%0b", vals[i], ovf, e.ovf); end
    end
  endtask

  task automatic test_ignore_start();
    int lat; int bhigh; exp_t e;
    @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(567);
    sb.push_back(model(567));
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    repeat (4) begin @(negedge clk); lat++; end
    start  = 1'b1;
    bin_in = BIN_W'(42);
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++; if (lat != LAT) begin failures++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bcd_out !== e.bcd) begin failures++; $display("FAIL ignore_bcd got=%h exp=%h", bcd_out, e.bcd); end
    @(negedge clk);
    bhigh = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (busy === 1'b1) bhigh++;
    end
    checks++; if (bhigh != 0) begin failures++; $display("FAIL ignore_no_requeue busy_cycles=%0d exp=0", bhigh); end
    checks++; if (bcd_out !== e.bcd) begin failures++; $display("FAIL ignore_hold got=%h exp=%h", bcd_out, e.bcd); end
  endtask

  task automatic test_reset_abort();
    int lat; logic b1; logic [15:0] bcd; logic ovf; exp_t e;
    @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(8000);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%0b exp=0", done); end
    checks++; if (bcd_out !== 16'h0000) begin failures++; $display("FAIL abort_bcd got=%h exp=0000", bcd_out); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL abort_ovf got=%0b exp=0", overflow); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_conv(305, lat, b1, bcd, ovf);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++; if (lat != LAT) begin failures++; $display("FAIL abort_restart_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bcd !== e.bcd) begin failures++; $display("FAIL abort_restart_bcd got=%h exp=%h", bcd, e.bcd); end
    checks++; if (ovf !== e.ovf) begin failures++; $display("FAIL abort_restart_ovf got=%0b exp=%0b", ovf, e.ovf); end
  endtask

  task automatic test_back_to_back();
    int n; int ndone; exp_t e;
    @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(77);
    sb.push_back(model(77));
    sb.push_back(model(4321));
    n = 0;
    ndone = 0;
    while (n < 45) begin
      @(negedge clk);
      n++;
      if (n == 1) bin_in = BIN_W'(4321);
      // Second conversion is accepted on edge 1 + PERIOD; release start after it.
      if (n == 1 + PERIOD) start = 1'b0;
      if (done === 1'b1) begin
        checks++;
        if (n != LAT + ndone * PERIOD) begin
          failures++; $display("FAIL b2b_done_time idx=%0d got=%0d exp=%0d", ndone, n, LAT + ndone * PERIOD);
        end
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL b2b_extra_done got=%h exp=none", bcd_out);
        end else begin
          e = sb.pop_front();
          if (bcd_out !== e.bcd) begin
            failures++; $display("FAIL b2b_bcd idx=%0d got=%h exp=%h", ndone, bcd_out, e.bcd);
          end
        end
        ndone++;
      end
    end
    start = 1'b0;
    checks++; if (ndone != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", ndone); end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit_reached exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
